// File: rtl/mem_port_arbiter_pkg.sv
// Memory-map constants and the owner tag shared by the BRAM/IO port arbiter.
// RAM sits at the bottom of core space; the four I/O registers sit at IO_BASE.
package mem_map_pkg;

  localparam int          RAM_AW   = 15;
  localparam logic [23:0] IO_BASE  = 24'hFF0000;

  localparam logic [1:0]  IO_BTN   = 2'd0;
  localparam logic [1:0]  IO_X     = 2'd1;
  localparam logic [1:0]  IO_Y     = 2'd2;
  localparam logic [1:0]  IO_COLOR = 2'd3;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VGA,
    OWN_CORE_RAM,
    OWN_CORE_IO
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Counts consecutive cycles a pending core RAM access loses to VGA and
// forces a core slot once the count reaches STARVE_LIMIT.
module mem_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic coreReq,
  input  logic coreRamReq,
  input  logic coreGnt,
  output logic forceCore
);

  logic [7:0] starveCnt;

  // Only force while a RAM access is actually pending.
  assign forceCore = coreRamReq && (starveCnt == 8'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= 8'd0;
    end else if (!coreReq || coreGnt) begin
      starveCnt <= 8'd0;
    end else if (coreRamReq && (starveCnt != 8'hFF)) begin
      starveCnt <= starveCnt + 8'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Per-cycle arbiter for the single-port frame BRAM (VGA priority, core
// starvation guard) plus decode of the core-side I/O register window.
module mem_port_arbiter #(
  parameter int          RAM_AW       = mem_map_pkg::RAM_AW,
  parameter int          STARVE_LIMIT = 8,
  parameter logic [23:0] IO_BASE      = mem_map_pkg::IO_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic [RAM_AW-1:0] vga_addr,
  output logic [15:0]       vga_rdata,
  output logic              vga_rvalid,
  output logic              vga_miss,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [23:0]       core_addr,
  input  logic [15:0]       core_wdata,
  output logic              core_gnt,
  output logic [15:0]       core_rdata,
  output logic              core_rvalid,
  input  logic [15:0]       io_btn,
  input  logic [15:0]       io_x,
  input  logic [15:0]       io_y,
  input  logic [15:0]       io_color,
  output logic              acc_read_pulse,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata
);

  import mem_map_pkg::*;

  logic        isRam;
  logic        isIo;
  logic [23:0] ioOff;
  logic        forceCore;
  logic        vgaWins;
  logic        coreRamGnt;
  logic        coreIoRd;
  logic [15:0] ioMux;

  owner_t      ramOwner;
  owner_t      ioOwner;
  logic        accPend;
  logic [15:0] ioData;
  logic [15:0] vgaHold;
  logic [15:0] coreHold;

  assign isRam = (core_addr >> RAM_AW) == 24'd0;
  // Wrap-around subtract: addresses below IO_BASE land far above 3.
  assign ioOff = core_addr - IO_BASE;
  assign isIo  = ioOff < 24'd4;

  assign vgaWins    = vga_req && !forceCore;
  assign coreRamGnt = core_req && isRam && !vgaWins;
  assign core_gnt   = core_req && (!isRam || !vgaWins);
  assign coreIoRd   = core_req && !core_we && !isRam;
  assign vga_miss   = vga_req && forceCore;

  assign ram_en    = vgaWins || coreRamGnt;
  assign ram_we    = coreRamGnt && core_we;
  assign ram_addr  = vgaWins ? vga_addr : (coreRamGnt ? core_addr[RAM_AW-1:0] : '0);
  assign ram_wdata = ram_we ? core_wdata : 16'h0000;

  always_comb begin
    ioMux = 16'h0000;
    case (ioOff[1:0])
      IO_BTN:   ioMux = io_btn;
      IO_X:     ioMux = io_x;
      IO_Y:     ioMux = io_y;
      IO_COLOR: ioMux = io_color;
      default:  ioMux = 16'h0000;
    endcase
  end

  mem_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) uStarve (
    .clk        (clk),
    .rst_n      (rst_n),
    .coreReq    (core_req),
    .coreRamReq (core_req && isRam),
    .coreGnt    (core_gnt),
    .forceCore  (forceCore)
  );

  // VGA and a core I/O read can complete in the same cycle, so the RAM
  // owner and the I/O read are tracked separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramOwner <= OWN_NONE;
      ioOwner  <= OWN_NONE;
      accPend  <= 1'b0;
      ioData   <= 16'h0000;
      vgaHold  <= 16'h0000;
      coreHold <= 16'h0000;
    end else begin
      if (ramOwner == OWN_VGA) vgaHold <= ram_rdata;
      if (ramOwner == OWN_CORE_RAM)     coreHold <= ram_rdata;
      else if (ioOwner == OWN_CORE_IO)  coreHold <= ioData;

      if (vgaWins)                      ramOwner <= OWN_VGA;
      else if (coreRamGnt && !core_we)  ramOwner <= OWN_CORE_RAM;
      else                              ramOwner <= OWN_NONE;

      ioOwner <= coreIoRd ? OWN_CORE_IO : OWN_NONE;
      accPend <= coreIoRd && isIo && (ioOff[1:0] == IO_COLOR);
      if (coreIoRd) ioData <= isIo ? ioMux : 16'h0000;
    end
  end

  assign vga_rvalid     = (ramOwner == OWN_VGA);
  assign vga_rdata      = vga_rvalid ? ram_rdata : vgaHold;
  assign core_rvalid    = (ramOwner == OWN_CORE_RAM) || (ioOwner == OWN_CORE_IO);
  assign core_rdata     = (ramOwner == OWN_CORE_RAM) ? ram_rdata :
                          (ioOwner == OWN_CORE_IO)   ? ioData : coreHold;
  assign acc_read_pulse = accPend;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand-written starvation and mid-flight reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vga_req;
  logic [14:0] vga_addr;
  logic [15:0] vga_rdata;
  logic        vga_rvalid;
  logic        vga_miss;
  logic        core_req;
  logic        core_we;
  logic [23:0] core_addr;
  logic [15:0] core_wdata;
  logic        core_gnt;
  logic [15:0] core_rdata;
  logic        core_rvalid;
  logic [15:0] io_btn;
  logic [15:0] io_x;
  logic [15:0] io_y;
  logic [15:0] io_color;
  logic        acc_read_pulse;
  logic        ram_en;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vga_req        (vga_req),
    .vga_addr       (vga_addr),
    .vga_rdata      (vga_rdata),
    .vga_rvalid     (vga_rvalid),
    .vga_miss       (vga_miss),
    .core_req       (core_req),
    .core_we        (core_we),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_gnt       (core_gnt),
    .core_rdata     (core_rdata),
    .core_rvalid    (core_rvalid),
    .io_btn         (io_btn),
    .io_x           (io_x),
    .io_y           (io_y),
    .io_color       (io_color),
    .acc_read_pulse (acc_read_pulse),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata)
  );

  // Behavioural single-port BRAM, 1-cycle read latency.
  logic [15:0] mem [0:32767];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        vReq;
    logic [14:0] vAddr;
    logic        cReq;
    logic        cWe;
    logic [23:0] cAddr;
    logic [15:0] cWdata;
    logic        eGnt;
    logic        eEn;
    logic        eWe;
    logic        eVvalid;
    logic [15:0] eVdata;
    logic        eCvalid;
    logic [15:0] eCdata;
    logic        eAcc;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vr, input logic [14:0] va, input logic cr,
                       input logic cw, input logic [23:0] ca, input logic [15:0] cd);
    vga_req    = vr;
    vga_addr   = va;
    core_req   = cr;
    core_we    = cw;
    core_addr  = ca;
    core_wdata = cd;
  endtask

  task automatic starveRun(input string tag);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      drive(1'b1, 15'h0010, 1'b1, 1'b0, 24'h000020, 16'h0000);
      #1;
      if (i < 9) begin
        chk({tag, "_gnt_denied"}, 32'(core_gnt), 32'd0);
        chk({tag, "_miss_quiet"}, 32'(vga_miss), 32'd0);
      end else begin
        chk({tag, "_gnt_forced"}, 32'(core_gnt), 32'd1);
        chk({tag, "_miss_pulse"}, 32'(vga_miss), 32'd1);
        chk({tag, "_ram_addr"},   32'(ram_addr), 32'h20);
        chk({tag, "_ram_we"},     32'(ram_we),   32'd0);
      end
      if (i >= 2) chk({tag, "_vga_rvalid"}, 32'(vga_rvalid), 32'd1);
    end
    @(negedge clk);
    drive(1'b1, 15'h0010, 1'b0, 1'b0, 24'h0, 16'h0);
    #1;
    chk({tag, "_after_vga_rvalid"},  32'(vga_rvalid),  32'd0);
    chk({tag, "_after_core_rvalid"}, 32'(core_rvalid), 32'd1);
    chk({tag, "_after_core_rdata"},  32'(core_rdata),  32'h7777);
    chk({tag, "_after_miss"},        32'(vga_miss),    32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 15'h0,    1'b1, 1'b1, 24'h000010, 16'hABCD, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 15'h0,    1'b1, 1'b1, 24'h000030, 16'h5A5A, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 15'h0010, 1'b1, 1'b0, 24'h000030, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 15'h0,    1'b1, 1'b0, 24'h000030, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'hABCD, 1'b0, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 15'h0,    1'b1, 1'b1, 24'h000020, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 16'hABCD, 1'b1, 16'h5A5A, 1'b0};
    vecs[5]  = '{1'b1, 15'h0020, 1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD, 1'b0, 16'h5A5A, 1'b0};
    vecs[6]  = '{1'b0, 15'h0,    1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h5A5A, 1'b0};
    vecs[7]  = '{1'b1, 15'h0010, 1'b1, 1'b0, 24'hFF0003, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h5A5A, 1'b0};
    vecs[8]  = '{1'b0, 15'h0,    1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD, 1'b1, 16'h00C3, 1'b1};
    vecs[9]  = '{1'b0, 15'h0,    1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'hABCD, 1'b0, 16'h00C3, 1'b0};
    vecs[10] = '{1'b1, 15'h0020, 1'b1, 1'b0, 24'h800000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'hABCD, 1'b0, 16'h00C3, 1'b0};
    vecs[11] = '{1'b0, 15'h0,    1'b1, 1'b1, 24'hFF0001, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h0000, 1'b0};
    vecs[12] = '{1'b0, 15'h0,    1'b1, 1'b0, 24'hFF0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0};
    vecs[13] = '{1'b1, 15'h0020, 1'b1, 1'b1, 24'h000020, 16'h7777, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 16'h5555, 1'b0};
    vecs[14] = '{1'b0, 15'h0,    1'b1, 1'b1, 24'h000020, 16'h7777, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h5555, 1'b0};
    vecs[15] = '{1'b1, 15'h0020, 1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h5555, 1'b0};
    vecs[16] = '{1'b0, 15'h0,    1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777, 1'b0, 16'h5555, 1'b0};
    vecs[17] = '{1'b0, 15'h0,    1'b1, 1'b0, 24'hFF0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7777, 1'b0, 16'h5555, 1'b0};
    vecs[18] = '{1'b0, 15'h0,    1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777, 1'b1, 16'h0001, 1'b0};

    io_btn   = 16'h0001;
    io_x     = 16'h5555;
    io_y     = 16'h0002;
    io_color = 16'h00C3;
    rst_n    = 1'b0;
    drive(1'b0, 15'h0, 1'b0, 1'b0, 24'h0, 16'h0);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_vga_rvalid",  32'(vga_rvalid),     32'd0);
    chk("rst_vga_rdata",   32'(vga_rdata),      32'd0);
    chk("rst_core_rvalid", 32'(core_rvalid),    32'd0);
    chk("rst_core_rdata",  32'(core_rdata),     32'd0);
    chk("rst_acc",         32'(acc_read_pulse), 32'd0);
    chk("rst_ram_en",      32'(ram_en),         32'd0);
    chk("rst_core_gnt",    32'(core_gnt),       32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].vReq, vecs[i].vAddr, vecs[i].cReq, vecs[i].cWe, vecs[i].cAddr, vecs[i].cWdata);
      #1;
      chk($sformatf("v%0d_core_gnt", i),    32'(core_gnt),       32'(vecs[i].eGnt));
      chk($sformatf("v%0d_ram_en", i),      32'(ram_en),         32'(vecs[i].eEn));
      chk($sformatf("v%0d_ram_we", i),      32'(ram_we),         32'(vecs[i].eWe));
      chk($sformatf("v%0d_vga_miss", i),    32'(vga_miss),       32'd0);
      chk($sformatf("v%0d_vga_rvalid", i),  32'(vga_rvalid),     32'(vecs[i].eVvalid));
      chk($sformatf("v%0d_vga_rdata", i),   32'(vga_rdata),      32'(vecs[i].eVdata));
      chk($sformatf("v%0d_core_rvalid", i), 32'(core_rvalid),    32'(vecs[i].eCvalid));
      chk($sformatf("v%0d_core_rdata", i),  32'(core_rdata),     32'(vecs[i].eCdata));
      chk($sformatf("v%0d_acc_pulse", i),   32'(acc_read_pulse), 32'(vecs[i].eAcc));
    end

    // Second run also proves the counter restarted from zero after the forced slot.
    starveRun("starve1");
    starveRun("starve2");

    // Reset while a granted I/O read is in flight.
    @(negedge clk);
    drive(1'b0, 15'h0, 1'b1, 1'b0, 24'hFF0003, 16'h0000);
    #1;
    chk("rfl_gnt", 32'(core_gnt), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 15'h0, 1'b0, 1'b0, 24'h0, 16'h0);
    #1;
    chk("rfl_core_rvalid", 32'(core_rvalid),    32'd0);
    chk("rfl_acc",         32'(acc_read_pulse), 32'd0);
    chk("rfl_core_rdata",  32'(core_rdata),     32'd0);
    chk("rfl_vga_rdata",   32'(vga_rdata),      32'd0);
    chk("rfl_vga_rvalid",  32'(vga_rvalid),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rel_core_rvalid", 32'(core_rvalid),    32'd0);
    chk("rel_acc",         32'(acc_read_pulse), 32'd0);
    @(negedge clk);
    drive(1'b1, 15'h0010, 1'b1, 1'b0, 24'h000030, 16'h0000);
    #1;
    chk("rel_gnt_blocked", 32'(core_gnt), 32'd0);
    @(negedge clk);
    drive(1'b0, 15'h0, 1'b0, 1'b0, 24'h0, 16'h0);
    #1;
    chk("rel_vga_rvalid", 32'(vga_rvalid), 32'd1);
    chk("rel_vga_rdata",  32'(vga_rdata),  32'hABCD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
